// File: rtl/tri_st_add_seq.sv
// Two-thread multi-cycle adder: one CW-bit lookahead slice walks a WIDTH-bit add/sub LSB chunk first.
// Define TRI_ST_ADD_SEQ_B2B_EN to let a new request issue from DONE in the same cycle the result is taken.
module tri_st_add_seq #(
  parameter int WIDTH = 64,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_val,
  output logic [1:0]       req_rdy,
  input  logic [0:WIDTH-1] req0_a,
  input  logic [0:WIDTH-1] req0_b,
  input  logic             req0_sub,
  input  logic [0:WIDTH-1] req1_a,
  input  logic [0:WIDTH-1] req1_b,
  input  logic             req1_sub,
  output logic             rsp_val,
  input  logic             rsp_rdy,
  output logic             rsp_tid,
  output logic [0:WIDTH-1] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam int N     = WIDTH / CW;
  localparam int NG    = CW / 8;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       gen;
    logic       xmit;
  } grp_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             tid_q, tid_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       grant;
  logic             hs;
  logic             hs_tid;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_sub;
  logic [CW-1:0]    ch_a, ch_b, ch_sum;
  logic [NG:0]      gc;
  logic             ch_cmsb;
  grp_t             grp_res;

  // 8-bit cell: ripple sum plus the group generate/transmit terms used for lookahead between cells
  function automatic grp_t grp8(input logic [7:0] x, input logic [7:0] y, input logic cin);
    grp_t       r;
    logic [7:0] gen, xmit, c;
    gen  = x & y;
    xmit = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 7; i++) c[i+1] = gen[i] | (xmit[i] & c[i]);
    r.sum = xmit ^ c;
    r.gen = gen[0];
    for (int i = 1; i < 8; i++) r.gen = gen[i] | (xmit[i] & r.gen);
    r.xmit = &xmit;
    return r;
  endfunction

  always_comb begin
    grant = req_val;
    if (req_val == 2'b11) grant = last_q ? 2'b01 : 2'b10;
  end

  always_comb begin
    req_rdy = 2'b00;
    if (!rst) begin
      if (state_q == IDLE) req_rdy = grant;
`ifdef TRI_ST_ADD_SEQ_B2B_EN
      else if (state_q == DONE && rsp_rdy) req_rdy = grant;
`else
      else req_rdy = 2'b00;
`endif
    end
  end

  assign hs      = |(req_val & req_rdy);
  assign hs_tid  = req_rdy[1];
  assign sel_a   = hs_tid ? req1_a : req0_a;
  assign sel_b   = hs_tid ? req1_b : req0_b;
  assign sel_sub = hs_tid ? req1_sub : req0_sub;

  always_comb begin
    ch_a = '0;
    ch_b = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        ch_a = a_q[k*CW +: CW];
        ch_b = b_q[k*CW +: CW];
      end
    end
  end

  always_comb begin
    grp_res = '0;
    ch_sum  = '0;
    gc      = '0;
    gc[0]   = carry_q;
    for (int j = 0; j < NG; j++) begin
      grp_res = grp8(ch_a[j*8 +: 8], ch_b[j*8 +: 8], gc[j]);
      ch_sum[j*8 +: 8] = grp_res.sum;
      gc[j+1] = grp_res.gen | (grp_res.xmit & gc[j]);
    end
  end

  // Carry into the top bit falls out of sum ^ a ^ b, so no extra chain is needed for overflow
  assign ch_cmsb = ch_sum[CW-1] ^ ch_a[CW-1] ^ ch_b[CW-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    tid_d   = tid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = IDLE;
      BUSY: begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CNT_W'(k)) sum_d[k*CW +: CW] = ch_sum;
        end
        carry_d = gc[NG];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_K) begin
          ovf_d   = ch_cmsb ^ gc[NG];
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Subtract is a + ~b + 1: the +1 rides in as the first chunk's carry
    if (hs) begin
      a_d     = sel_a;
      b_d     = sel_sub ? ~sel_b : sel_b;
      carry_d = sel_sub;
      cnt_d   = '0;
      tid_d   = hs_tid;
      last_d  = hs_tid;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      tid_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      tid_q   <= tid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_val  = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign rsp_tid  = tid_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = carry_q;
  assign rsp_ovf  = ovf_q;

endmodule

// File: tb/tb_tri_st_add_seq.sv
// Bench for tri_st_add_seq: directed vector table, hand-built reset/hold sequences and
// randomized two-thread traffic scored against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_tri_st_add_seq;

  localparam int WIDTH = 64;
  localparam int CW    = 16;
  localparam int N     = WIDTH / CW;
`ifdef TRI_ST_ADD_SEQ_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam int RSP_GAP = B2B ? N + 1 : N + 2;
  localparam int NV = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_val, req_rdy;
  logic [0:WIDTH-1] req0_a, req0_b, req1_a, req1_b;
  logic             req0_sub, req1_sub;
  logic             rsp_val, rsp_rdy, rsp_tid, rsp_cout, rsp_ovf, busy;
  logic [0:WIDTH-1] rsp_sum;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last;
  int rsp_tids[$];

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  typedef struct {
    string            name;
    bit               tid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit               sub;
    logic [WIDTH-1:0] sum;
    bit               cout;
    bit               ovf;
  } vec_t;

  vec_t vecs [NV];

  tri_st_add_seq #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_tid(rsp_tid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: whole-word arithmetic, sign-rule overflow, unsigned compare for borrow
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    res_t           r;
    logic [WIDTH:0] full;
    if (sub) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      r.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b};
      r.sum  = full[WIDTH-1:0];
      r.cout = full[WIDTH];
      r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    end
    return r;
  endfunction

  function automatic logic [1:0] rr_grant(input logic [1:0] v, input bit last);
    if (v == 2'b11) return (last == 1'b1) ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(3))
      0:       return {WIDTH{1'b1}} << $urandom_range(WIDTH - 1);
      1:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit tid, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    if (tid) begin
      req1_a = a; req1_b = b; req1_sub = sub; req_val[1] = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_sub = sub; req_val[0] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_val = 2'b00; rsp_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  // One isolated op from IDLE, optionally stalling the consumer for 'hold' cycles in DONE
  task automatic run_vec(input vec_t v, input int hold);
    int         waited;
    int         lat;
    logic [1:0] want;
    want = v.tid ? 2'b10 : 2'b01;
    req_val = 2'b00;
    applyStimulus(v.tid, v.a, v.b, v.sub);
    #1;
    waited = 0;
    while (req_rdy !== want && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput($sformatf("%s grant", v.name), req_rdy, want);
    tick();
    req_val = 2'b00;
    model_last = v.tid;
    checkOutput($sformatf("%s busy", v.name), busy, 1'b1);
    lat = 1;
    while (rsp_val !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput($sformatf("%s latency", v.name), lat, N + 1);
    checkOutput($sformatf("%s sum", v.name), rsp_sum, v.sum);
    checkOutput($sformatf("%s cout", v.name), rsp_cout, v.cout);
    checkOutput($sformatf("%s ovf", v.name), rsp_ovf, v.ovf);
    checkOutput($sformatf("%s tid", v.name), rsp_tid, v.tid);
    for (int h = 0; h < hold; h++) begin
      req_val = 2'b11; rsp_rdy = 1'b0;
      #1;
      checkOutput($sformatf("%s hold%0d req_rdy", v.name, h), req_rdy, 2'b00);
      tick();
      checkOutput($sformatf("%s hold%0d rsp_val", v.name, h), rsp_val, 1'b1);
      checkOutput($sformatf("%s hold%0d busy", v.name, h), busy, 1'b1);
      checkOutput($sformatf("%s hold%0d sum", v.name, h), rsp_sum, v.sum);
      checkOutput($sformatf("%s hold%0d cout", v.name, h), rsp_cout, v.cout);
      checkOutput($sformatf("%s hold%0d ovf", v.name, h), rsp_ovf, v.ovf);
      checkOutput($sformatf("%s hold%0d tid", v.name, h), rsp_tid, v.tid);
    end
    req_val = 2'b00; rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    checkOutput($sformatf("%s rsp_val drop", v.name), rsp_val, 1'b0);
    checkOutput($sformatf("%s idle", v.name), busy, 1'b0);
  endtask

  // Cycle-stepped traffic: requesters hold until granted, model tracks the single op in flight
  task automatic run_traffic(input int n_rsp, input int req_pct, input int rdy_pct, input int budget, input bit check_gap);
    logic [WIDTH-1:0] pa [2];
    logic [WIDTH-1:0] pb [2];
    logic             ps [2];
    bit               pend [2];
    bit               inflight;
    bit               done_now;
    bit               exp_tid;
    int               hs_cyc, got, cyc, last_rsp_cyc, t;
    res_t             exp_r;
    logic [1:0]       exp_rdy;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; ps[i] = 1'b0;
    end
    inflight = 1'b0; exp_tid = 1'b0; exp_r = '0;
    hs_cyc = 0; got = 0; cyc = 0; last_rsp_cyc = -1;
    while (got < n_rsp && cyc < budget) begin
      req_val = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(99) < req_pct) begin
          pend[i] = 1'b1;
          pa[i] = rand_operand();
          pb[i] = rand_operand();
          ps[i] = $urandom_range(1);
        end
        if (pend[i]) applyStimulus(i[0], pa[i], pb[i], ps[i]);
      end
      rsp_rdy = ($urandom_range(99) < rdy_pct);
      #1;
      done_now = inflight && (cyc - hs_cyc >= N + 1);
      checkOutput("traffic rsp_val", rsp_val, done_now);
      checkOutput("traffic busy", busy, inflight);
      if (done_now) begin
        if (cyc - hs_cyc == N + 1) begin
          rsp_tids.push_back(int'(exp_tid));
          if (check_gap && last_rsp_cyc >= 0) checkOutput("traffic rsp gap", cyc - last_rsp_cyc, RSP_GAP);
          last_rsp_cyc = cyc;
        end
        checkOutput("traffic sum", rsp_sum, exp_r.sum);
        checkOutput("traffic cout", rsp_cout, exp_r.cout);
        checkOutput("traffic ovf", rsp_ovf, exp_r.ovf);
        checkOutput("traffic tid", rsp_tid, exp_tid);
      end
      exp_rdy = 2'b00;
      if (!inflight || (B2B && done_now && rsp_rdy)) exp_rdy = rr_grant(req_val, model_last);
      checkOutput("traffic req_rdy", req_rdy, exp_rdy);
      if (done_now && rsp_rdy) begin
        got++;
        inflight = 1'b0;
      end
      if (exp_rdy != 2'b00) begin
        t = exp_rdy[1] ? 1 : 0;
        exp_r = model(pa[t], pb[t], ps[t]);
        exp_tid = t[0];
        inflight = 1'b1;
        hs_cyc = cyc;
        model_last = t[0];
        pend[t] = 1'b0;
      end
      tick();
      cyc++;
    end
    req_val = 2'b00; rsp_rdy = 1'b0;
    checkOutput("traffic completion", got, n_rsp);
  endtask

  task automatic reset_mid_busy();
    bit seen;
    do_reset();
    req_val = 2'b00;
    applyStimulus(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    #1;
    checkOutput("rstbusy grant", req_rdy, 2'b01);
    tick();
    req_val = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rstbusy rsp_val", rsp_val, 1'b0);
    checkOutput("rstbusy busy", busy, 1'b0);
    checkOutput("rstbusy sum", rsp_sum, 64'h0);
    checkOutput("rstbusy cout", rsp_cout, 1'b0);
    checkOutput("rstbusy ovf", rsp_ovf, 1'b0);
    checkOutput("rstbusy tid", rsp_tid, 1'b0);
    rst = 1'b0;
    model_last = 1'b1;
    applyStimulus(1'b0, 64'h5, 64'h3, 1'b0);
    #1;
    checkOutput("rstbusy grant after release", req_rdy, 2'b01);
    req_val = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      tick();
      if (rsp_val === 1'b1) seen = 1'b1;
    end
    checkOutput("rstbusy discarded op", seen, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_val = 2'b11; rsp_rdy = 1'b0;
    req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    model_last = 1'b1;

    vecs[0] = '{"add carry c0-c1", 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{"sub min-1",       1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[2] = '{"add wrap",        1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[3] = '{"add max+1",       1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{"sub equal",       1'b0, 64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[5] = '{"sub borrow",      1'b1, 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[6] = '{"add two chains",  1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0};
    vecs[7] = '{"sub cross chunk", 1'b1, 64'h0000_0001_0000_0000, 64'h1, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};

    tick();
    checkOutput("reset req_rdy forced", req_rdy, 2'b00);
    checkOutput("reset rsp_val", rsp_val, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset sum", rsp_sum, 64'h0);
    checkOutput("reset cout", rsp_cout, 1'b0);
    checkOutput("reset ovf", rsp_ovf, 1'b0);
    checkOutput("reset tid", rsp_tid, 1'b0);
    tick();
    rst = 1'b0; req_val = 2'b00;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], (i == 1) ? 3 : 0);

    do_reset();
    rsp_tids.delete();
    run_traffic(3, 100, 100, 200, 1'b1);
    if (rsp_tids.size() < 3) begin
      checkOutput("rr response count", rsp_tids.size(), 3);
    end else begin
      checkOutput("rr first tid", rsp_tids[0], 0);
      checkOutput("rr second tid", rsp_tids[1], 1);
      checkOutput("rr third tid", rsp_tids[2], 0);
    end

    reset_mid_busy();

    run_traffic(40, 50, 60, 4000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
